// File: rtl/long_fifo_arb_pkg.sv
// Shared definitions for the long-FIFO write arbiter and its read-side unpacker.
// Beat word layout on the FIFO: {last, src_id, payload}.
package long_fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOCK = 2'd1,
    ST_DROP = 2'd2
  } arb_state_e;

  function automatic int unsigned idw_of(input int unsigned num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

  function automatic int unsigned din_width(input int unsigned dsize, input int unsigned num);
    return dsize + idw_of(num) + 1;
  endfunction

  // Field positions inside the FIFO word, shared with the unpacker.
  function automatic int unsigned id_lsb(input int unsigned dsize);
    return dsize;
  endfunction

  function automatic int unsigned last_pos(input int unsigned dsize, input int unsigned num);
    return dsize + idw_of(num);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_grant, with wrap.
module rr_pick
  import long_fifo_arb_pkg::*;
#(
  parameter int unsigned NUM = 4,
  localparam int unsigned IDW = idw_of(NUM)
) (
  input  logic [NUM-1:0] req_i,
  input  logic [IDW-1:0] last_grant_i,
  output logic [NUM-1:0] gnt_onehot_o,
  output logic [IDW-1:0] gnt_idx_o,
  output logic           any_req_o
);

  logic [IDW-1:0] cand;

  always_comb begin : pick
    gnt_onehot_o = '0;
    gnt_idx_o    = '0;
    any_req_o    = 1'b0;
    cand         = '0;
    for (int unsigned off = 1; off <= NUM; off++) begin
      cand = IDW'((32'(last_grant_i) + off) % NUM);
      if (!any_req_o && req_i[cand]) begin
        any_req_o           = 1'b1;
        gnt_idx_o           = cand;
        gnt_onehot_o[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/long_fifo_wr_arbiter.sv
// Packet-level round-robin arbiter sharing one long-FIFO write port between NUM streams,
// truncating packets longer than MAX_LEN beats.
module long_fifo_wr_arbiter
  import long_fifo_arb_pkg::*;
#(
  parameter int unsigned NUM     = 4,
  parameter int unsigned DSIZE   = 10,
  parameter int unsigned MAX_LEN = 1024,
  localparam int unsigned IDW    = idw_of(NUM),
  localparam int unsigned DINW   = din_width(DSIZE, NUM)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM-1:0][DSIZE-1:0]  s_data_i,
  input  logic [NUM-1:0]             s_valid_i,
  input  logic [NUM-1:0]             s_last_i,
  output logic [NUM-1:0]             s_ready_o,
  output logic [DINW-1:0]            fifo_din_o,
  output logic                       fifo_wr_en_o,
  input  logic                       fifo_full_i,
  output logic [IDW-1:0]             grant_id_o,
  output logic                       busy_o,
  output logic                       trunc_err_o,
  output logic [15:0]                pkt_cnt_o
);

  localparam int unsigned CNTW      = $clog2(MAX_LEN + 1);
  localparam int unsigned LAST_POS  = last_pos(DSIZE, NUM);
  localparam int unsigned ID_LSB    = id_lsb(DSIZE);
  localparam logic [IDW-1:0]  LAST_INIT  = IDW'(NUM - 1);
  localparam logic [CNTW-1:0] BEAT_LIMIT = CNTW'(MAX_LEN - 1);

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [CNTW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [15:0]      pkt_cnt_q, pkt_cnt_d;
  logic             busy_q;
  logic             trunc_q, trunc_d;

  logic [NUM-1:0]   pick_onehot;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic             accept;
  logic             force_last;

  rr_pick #(
    .NUM (NUM)
  ) u_rr_pick (
    .req_i        (s_valid_i),
    .last_grant_i (last_grant_q),
    .gnt_onehot_o (pick_onehot),
    .gnt_idx_o    (pick_idx),
    .any_req_o    (pick_any)
  );

  always_comb begin : pick_onehot_chk
    if (pick_any) begin
      assert (pick_onehot == (NUM'(1) << pick_idx));
    end
  end

  assign force_last = (beat_cnt_q == BEAT_LIMIT);

  // Zero-latency handshake so fifo_full is honoured in the same cycle.
  always_comb begin : out_mux
    s_ready_o    = '0;
    fifo_wr_en_o = 1'b0;
    fifo_din_o   = '0;
    accept       = 1'b0;
    case (state_q)
      ST_LOCK: begin
        s_ready_o[grant_q]         = ~fifo_full_i;
        accept                     = s_valid_i[grant_q] & ~fifo_full_i;
        fifo_wr_en_o               = accept;
        fifo_din_o[LAST_POS]       = s_last_i[grant_q] | force_last;
        fifo_din_o[ID_LSB +: IDW]  = grant_q;
        fifo_din_o[DSIZE-1:0]      = s_data_i[grant_q];
      end
      ST_DROP: begin
        s_ready_o[grant_q] = 1'b1;
        accept             = s_valid_i[grant_q];
      end
      default: ;
    endcase
  end

  always_comb begin : next_state
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    pkt_cnt_d    = pkt_cnt_q;
    trunc_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + CNTW'(1);
          if (s_last_i[grant_q]) begin
            pkt_cnt_d    = pkt_cnt_q + 16'd1;
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end else if (force_last) begin
            // Oversize packet: close it in the FIFO, swallow the remainder.
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            trunc_d   = 1'b1;
            state_d   = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (accept && s_last_i[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_INIT;
      beat_cnt_q   <= '0;
      pkt_cnt_q    <= '0;
      busy_q       <= 1'b0;
      trunc_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      pkt_cnt_q    <= pkt_cnt_d;
      busy_q       <= (state_d != ST_IDLE);
      trunc_q      <= trunc_d;
    end
  end

  assign grant_id_o  = grant_q;
  assign busy_o      = busy_q;
  assign trunc_err_o = trunc_q;
  assign pkt_cnt_o   = pkt_cnt_q;

endmodule

// File: tb/tb_long_fifo_wr_arbiter.sv
// Randomized bench for long_fifo_wr_arbiter: per-cycle behavioural model plus per-source
// packet scoreboard, with directed scenarios for ordering, backpressure, truncation and reset.
module tb_long_fifo_wr_arbiter;

  localparam int unsigned NUM     = 4;
  localparam int unsigned DSIZE   = 10;
  localparam int unsigned MAX_LEN = 4;
  localparam int unsigned IDW     = 2;
  localparam int unsigned DINW    = DSIZE + IDW + 1;

  typedef logic [DSIZE:0] beat_t;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM-1:0][DSIZE-1:0] s_data;
  logic [NUM-1:0]            s_valid;
  logic [NUM-1:0]            s_last;
  logic [NUM-1:0]            s_ready;
  logic [DINW-1:0]           fifo_din;
  logic                      fifo_wr_en;
  logic                      fifo_full;
  logic [IDW-1:0]            grant_id;
  logic                      busy;
  logic                      trunc_err;
  logic [15:0]               pkt_cnt;

  long_fifo_wr_arbiter #(
    .NUM     (NUM),
    .DSIZE   (DSIZE),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_data_i     (s_data),
    .s_valid_i    (s_valid),
    .s_last_i     (s_last),
    .s_ready_o    (s_ready),
    .fifo_din_o   (fifo_din),
    .fifo_wr_en_o (fifo_wr_en),
    .fifo_full_i  (fifo_full),
    .grant_id_o   (grant_id),
    .busy_o       (busy),
    .trunc_err_o  (trunc_err),
    .pkt_cnt_o    (pkt_cnt)
  );

  always #5 clk = ~clk;

  beat_t src_q [NUM][$];
  beat_t exp_q [NUM][$];
  int    pkt_order[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    gap_pct = 0;
  int    full_pct = 0;
  int    full_hold = 0;
  int    mute [NUM];
  int    trunc_seen = 0;
  int    beats_written = 0;
  logic [NUM-1:0] fire;

  // Reference model: who owns the port, whether the rest is being discarded, counters.
  int    m_owner;
  int    m_last;
  int    m_gid;
  int    m_beats;
  bit    m_drop;
  int    m_pkt;
  bit    m_trunc;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = NUM - 1; m_gid = 0; m_beats = 0;
    m_drop = 1'b0; m_pkt = 0; m_trunc = 1'b0;
  endtask

  task automatic add_pkt(input int src, input int len);
    for (int k = 0; k < len; k++) begin
      logic [DSIZE-1:0] d;
      d = DSIZE'($urandom);
      src_q[src].push_back({1'(k == len - 1), d});
      if (k < int'(MAX_LEN))
        exp_q[src].push_back({1'((k == len - 1) || (k == int'(MAX_LEN) - 1)), d});
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM; i++) begin
      bit muted;
      beat_t b;
      if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      muted = (mute[i] > 0);
      if (muted) mute[i]--;
      if (src_q[i].size() > 0 && !muted && int'($urandom_range(99)) >= gap_pct) begin
        b = src_q[i][0];
        s_valid[i] = 1'b1;
        s_last[i]  = b[DSIZE];
        s_data[i]  = b[DSIZE-1:0];
      end else begin
        s_valid[i] = 1'b0;
        s_last[i]  = 1'($urandom);
        s_data[i]  = DSIZE'($urandom);
      end
    end
    if (full_hold > 0) begin
      fifo_full = 1'b1;
      full_hold--;
    end else begin
      fifo_full = (int'($urandom_range(99)) < full_pct);
    end
  endtask

  task automatic sample();
    logic [NUM-1:0]  e_ready;
    logic            e_wr;
    logic [DINW-1:0] e_din;
    logic [IDW-1:0]  o;
    bit              acc;
    bit              new_trunc;
    int              src;
    e_ready = '0; e_wr = 1'b0; e_din = '0; o = IDW'(m_gid);
    if (m_owner >= 0) begin
      if (!m_drop) begin
        e_ready[o] = ~fifo_full;
        e_wr       = s_valid[o] & ~fifo_full;
        e_din      = {1'(s_last[o] || (m_beats == int'(MAX_LEN) - 1)), o, s_data[o]};
      end else begin
        e_ready[o] = 1'b1;
      end
    end
    check_eq("s_ready", 64'(s_ready), 64'(e_ready));
    check_eq("wr_en", 64'(fifo_wr_en), 64'(e_wr));
    if (e_wr) check_eq("din", 64'(fifo_din), 64'(e_din));
    check_eq("busy", 64'(busy), 64'(m_owner >= 0));
    check_eq("grant_id", 64'(grant_id), 64'(m_gid));
    check_eq("trunc_err", 64'(trunc_err), 64'(m_trunc));
    check_eq("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));

    fire = s_valid & s_ready;
    if (trunc_err) trunc_seen++;
    if (fifo_wr_en) begin
      src = int'(fifo_din[DSIZE +: IDW]);
      beats_written++;
      check_eq("sb_beat_expected", 64'(exp_q[src].size() != 0), 64'd1);
      if (exp_q[src].size() != 0)
        check_eq("sb_beat", 64'({fifo_din[DINW-1], fifo_din[DSIZE-1:0]}), 64'(exp_q[src].pop_front()));
      if (fifo_din[DINW-1]) pkt_order.push_back(src);
    end

    new_trunc = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= NUM; k++) begin
        int c;
        c = (m_last + k) % NUM;
        if (m_owner < 0 && s_valid[c]) begin
          m_owner = c; m_gid = c; m_beats = 0; m_drop = 1'b0;
        end
      end
    end else begin
      acc = s_valid[o] && (m_drop || !fifo_full);
      if (acc && m_drop) begin
        if (s_last[o]) begin m_last = m_owner; m_owner = -1; end
      end else if (acc) begin
        m_beats++;
        if (s_last[o]) begin
          m_pkt = (m_pkt + 1) % 65536; m_last = m_owner; m_owner = -1;
        end else if (m_beats == int'(MAX_LEN)) begin
          m_pkt = (m_pkt + 1) % 65536; new_trunc = 1'b1; m_drop = 1'b1;
        end
      end
    end
    m_trunc = new_trunc;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    drive();
    @(negedge clk);
    sample();
  endtask

  function automatic bit pending();
    for (int i = 0; i < NUM; i++) if (src_q[i].size() > 0) return 1'b1;
    return (m_owner >= 0);
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      cycle();
      n++;
    end
    check_eq("drain_in_budget", 64'(n < budget), 64'd1);
  endtask

  task automatic check_order(input string tag, input int a, input int b);
    check_eq({tag, "_count"}, 64'(pkt_order.size()), 64'd2);
    if (pkt_order.size() == 2) begin
      check_eq({tag, "_first"}, 64'(pkt_order[0]), 64'(a));
      check_eq({tag, "_second"}, 64'(pkt_order[1]), 64'(b));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int left;
    rst_n = 1'b0; s_valid = '0; s_last = '0; s_data = '0; fifo_full = 1'b0; fire = '0;
    for (int i = 0; i < NUM; i++) mute[i] = 0;
    model_reset();
    #12;
    check_eq("rst_s_ready", 64'(s_ready), 64'd0);
    check_eq("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    check_eq("rst_din", 64'(fifo_din), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_grant", 64'(grant_id), 64'd0);
    check_eq("rst_trunc", 64'(trunc_err), 64'd0);
    check_eq("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // All four start together: served 0,1,2,3 with one idle cycle between packets.
    for (int i = 0; i < NUM; i++) add_pkt(i, 3);
    drain(200);
    check_eq("a_npkts", 64'(pkt_order.size()), 64'd4);
    for (int i = 0; i < pkt_order.size(); i++) check_eq("a_order", 64'(pkt_order[i]), 64'(i));
    check_eq("a_pkt_cnt", 64'(pkt_cnt), 64'd4);

    // After src 1 finishes, src 3 outranks src 1.
    add_pkt(1, 2);
    drain(200);
    pkt_order.delete();
    add_pkt(1, 2);
    add_pkt(3, 2);
    drain(200);
    check_order("b_rr", 3, 1);

    // Five cycles of full mid-packet.
    add_pkt(2, 6);
    repeat (3) cycle();
    full_hold = 5;
    repeat (5) cycle();
    check_eq("c_busy", 64'(busy), 64'd1);
    check_eq("c_grant", 64'(grant_id), 64'd2);
    drain(200);

    // Seven-beat packet truncated to four, then a clean follow-up packet.
    trunc_seen = 0; beats_written = 0; pkt_order.delete();
    add_pkt(1, 7);
    drain(200);
    check_eq("d_trunc_pulses", 64'(trunc_seen), 64'd1);
    check_eq("d_beats", 64'(beats_written), 64'd4);
    add_pkt(0, 2);
    drain(200);
    check_eq("d_beats_after", 64'(beats_written), 64'd6);
    check_order("d_order", 1, 0);

    // src 2 stalls mid-packet; src 0 waits for its last beat.
    pkt_order.delete();
    add_pkt(2, 5);
    repeat (2) cycle();
    mute[2] = 10;
    add_pkt(0, 3);
    repeat (12) cycle();
    check_eq("e_grant_held", 64'(grant_id), 64'd2);
    drain(200);
    check_order("e_order", 2, 0);

    // Random traffic with gaps, backpressure and oversize packets.
    gap_pct = 30; full_pct = 25;
    for (int p = 0; p < 150; p++) add_pkt(int'($urandom_range(NUM - 1)), int'($urandom_range(7, 1)));
    drain(20000);
    left = 0;
    for (int i = 0; i < NUM; i++) left += exp_q[i].size();
    check_eq("rand_leftover", 64'(left), 64'd0);
    gap_pct = 0; full_pct = 0;

    // Asynchronous reset while locked.
    add_pkt(3, 6);
    repeat (3) cycle();
    check_eq("f_pre_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("f_rst_ready", 64'(s_ready), 64'd0);
    check_eq("f_rst_wr_en", 64'(fifo_wr_en), 64'd0);
    check_eq("f_rst_busy", 64'(busy), 64'd0);
    check_eq("f_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    for (int i = 0; i < NUM; i++) begin
      src_q[i].delete(); exp_q[i].delete();
    end
    pkt_order.delete();
    model_reset();
    fire = '0; s_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    add_pkt(1, 2);
    add_pkt(0, 2);
    drain(200);
    check_order("f_restart", 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
